// File: rtl/quad_steer_enc.sv
// -----------------------------------------------------------------------------
// quad_steer_enc
//
// Multi-channel joystick-to-quadrature steering encoder. Each channel turns
// a left/right request pair into a 2-bit Gray-code stream (steer_a = phase[1],
// steer_b = phase[0]). While a direction is held, the phase advances one step
// every clkdiv+1 cycles. Releasing, pressing both buttons, or reversing the
// direction restarts the step timer without moving the phase.
//
// Optional feature (macro QUAD_ACCEL_EN): hold-acceleration. After
// ACCEL_STEPS consecutive steps in one direction the step threshold halves.
// After 2*ACCEL_STEPS steps it is quartered. Any idle or reversal cycle
// returns the channel to the base rate. When the macro is undefined the
// per-channel hold counter is not built.
//
// Parameters:
//   CHANNELS     number of independent channels (1..8)
//   DIV_W        width of clkdiv and of the per-channel step counter
//   ACCEL_STEPS  steps per acceleration stage (QUAD_ACCEL_EN only)
//
// Ports:
//   CLK      in   system clock
//   Reset_n  in   asynchronous active-low reset
//   clkdiv   in   step threshold; the step interval is clkdiv+1 cycles
//   right    in   per-channel right request, active high
//   left     in   per-channel left request, active high
//   steer_a  out  per-channel quadrature A (phase bit 1), registered
//   steer_b  out  per-channel quadrature B (phase bit 0), registered
//   moving   out  per-channel direction-valid flag, registered
// -----------------------------------------------------------------------------
module quad_steer_enc #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int ACCEL_STEPS = 8
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [DIV_W-1:0]    clkdiv,
    input  logic [CHANNELS-1:0] right,
    input  logic [CHANNELS-1:0] left,
    output logic [CHANNELS-1:0] steer_a,
    output logic [CHANNELS-1:0] steer_b,
    output logic [CHANNELS-1:0] moving
);

    if (CHANNELS < 1 || CHANNELS > 8 || ACCEL_STEPS < 1) begin : g_param_check
        $error("quad_steer_enc: CHANNELS must be 1..8 and ACCEL_STEPS >= 1");
    end

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_R    = 2'd1,
        DIR_L    = 2'd2
    } dir_t;

    // Per-channel state
    dir_t             dir_q     [CHANNELS];
    logic [1:0]       phase_q   [CHANNELS];
    logic [DIV_W-1:0] count_q   [CHANNELS];
    logic             moving_q  [CHANNELS];

    // Next-state values
    dir_t             dir_dec   [CHANNELS];
    dir_t             dir_nxt   [CHANNELS];
    logic [1:0]       phase_nxt [CHANNELS];
    logic [DIV_W-1:0] count_nxt [CHANNELS];
    logic             moving_nxt[CHANNELS];
    logic             step      [CHANNELS];
    logic [DIV_W-1:0] thr       [CHANNELS];

`ifdef QUAD_ACCEL_EN
    localparam int HOLD_W = $clog2(2 * ACCEL_STEPS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MID = HOLD_W'(ACCEL_STEPS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(2 * ACCEL_STEPS);

    logic [HOLD_W-1:0] hold_q   [CHANNELS];
    logic [HOLD_W-1:0] hold_nxt [CHANNELS];
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every per-channel register, arrays included, is reset so the
    // outputs are defined the instant Reset_n falls; these are a handful of
    // flops per channel, not a RAM, so there is no reason to leave any unreset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                dir_q[i]    <= DIR_IDLE;
                phase_q[i]  <= 2'b00;
                count_q[i]  <= '0;
                moving_q[i] <= 1'b0;
`ifdef QUAD_ACCEL_EN
                hold_q[i]   <= '0;
`endif
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the pre-edge state, regardless of order.
            for (int i = 0; i < CHANNELS; i++) begin
                dir_q[i]    <= dir_nxt[i];
                phase_q[i]  <= phase_nxt[i];
                count_q[i]  <= count_nxt[i];
                moving_q[i] <= moving_nxt[i];
`ifdef QUAD_ACCEL_EN
                hold_q[i]   <= hold_nxt[i];
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step threshold
    // -------------------------------------------------------------------------
`ifdef QUAD_ACCEL_EN
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (hold_q[i] >= HOLD_MAX) begin
                thr[i] = clkdiv >> 2;
            end else if (hold_q[i] >= HOLD_MID) begin
                thr[i] = clkdiv >> 1;
            end else begin
                thr[i] = clkdiv;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            thr[i] = clkdiv;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: each output of this block gets a default before any
            // branch, so no path can leave it unassigned and infer a latch.
            dir_dec[i]    = DIR_IDLE;
            dir_nxt[i]    = dir_q[i];
            phase_nxt[i]  = phase_q[i];
            count_nxt[i]  = count_q[i];
            step[i]       = 1'b0;

            // Both buttons pressed decodes as idle.
            case ({right[i], left[i]})
                2'b10:   dir_dec[i] = DIR_R;
                2'b01:   dir_dec[i] = DIR_L;
                default: dir_dec[i] = DIR_IDLE;
            endcase

            moving_nxt[i] = (dir_dec[i] != DIR_IDLE);

            if (dir_dec[i] == DIR_IDLE) begin
                dir_nxt[i]   = DIR_IDLE;
                count_nxt[i] = '0;
            end else if (dir_dec[i] != dir_q[i]) begin
                // Onset or reversal: latch the direction and restart timing.
                dir_nxt[i]   = dir_dec[i];
                count_nxt[i] = '0;
            end else if (count_q[i] >= thr[i]) begin
                // >= rather than == so a threshold lowered mid-hold below the
                // current count fires next cycle instead of wrapping.
                step[i]      = 1'b1;
                count_nxt[i] = '0;
                if (dir_q[i] == DIR_R) begin
                    // 00 -> 01 -> 11 -> 10 -> 00
                    phase_nxt[i] = {phase_q[i][0], ~phase_q[i][1]};
                end else begin
                    // 00 -> 10 -> 11 -> 01 -> 00
                    phase_nxt[i] = {~phase_q[i][0], phase_q[i][1]};
                end
            end else begin
                count_nxt[i] = count_q[i] + DIV_W'(1);
            end
        end
    end

`ifdef QUAD_ACCEL_EN
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hold_nxt[i] = hold_q[i];
            if (dir_dec[i] == DIR_IDLE || dir_dec[i] != dir_q[i]) begin
                hold_nxt[i] = '0;
            end else if (step[i] && hold_q[i] != HOLD_MAX) begin
                hold_nxt[i] = hold_q[i] + HOLD_W'(1);
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs: straight from registers, no logic after the flops.
    // -------------------------------------------------------------------------
    always_comb begin
        steer_a = '0;
        steer_b = '0;
        moving  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            steer_a[i] = phase_q[i][1];
            steer_b[i] = phase_q[i][0];
            moving[i]  = moving_q[i];
        end
    end

endmodule

// File: doc/quad_steer_enc.md
Name: quad_steer_enc

Overview:
- Parametrised, multi-channel successor to the single-channel joystick-to-quadrature steering converter.
- Turns digital left/right requests into 2-bit Gray-code quadrature streams, one stream per player, for the arcade core's steering inputs.
- Sits between the joystick/keyboard merge logic and the core's Steer_xA/Steer_xB pins, replacing one converter instance per player.
- Adds a runtime step period, reversal handling, and optional hold-acceleration.

Parameters:
- CHANNELS, 2: number of independent steering channels (1..8).
- DIV_W, 16: width of the step-period counter and of the clkdiv input.
- ACCEL_STEPS, 8: consecutive same-direction steps per acceleration stage. Used only with QUAD_ACCEL_EN.

Ports:
- CLK  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- clkdiv  in  DIV_W  step threshold. Step interval is clkdiv+1 CLK cycles.
- right  in  CHANNELS  per-channel right request, active high.
- left  in  CHANNELS  per-channel left request, active high.
- steer_a  out  CHANNELS  quadrature A (phase bit 1), registered.
- steer_b  out  CHANNELS  quadrature B (phase bit 0), registered.
- moving  out  CHANNELS  1 while channel direction is valid (exactly one of left/right), registered.

Behaviour:
- Reset (async assert, sync release): every channel's phase=00, count=0, hold=0, dir=idle. Outputs steer_a=0, steer_b=0, moving=0.
- Per-channel state:
  - phase[1:0]
  - count[DIV_W-1:0]
  - dir (idle/R/L)
  - hold step counter, saturating at 2*ACCEL_STEPS
- Direction decode each cycle: right&~left gives R; left&~right gives L; otherwise idle (both pressed = idle).
- Idle: count and hold cleared, phase frozen, moving=0 next cycle.
- Decoded direction differs from registered dir (onset or reversal):
  - dir updated, count and hold cleared, no step that cycle.
  - moving=1 next cycle if the new direction is not idle.
- Same direction:
  - If count >= thr: step, count cleared, hold incremented (saturating).
  - Otherwise count increments.
  - The >= compare means a mid-hold clkdiv decrease below count fires on the next cycle. No wrap past 2^DIV_W-1.
- Step sequence:
  - R: 00->01->11->10->00.
  - L: 00->10->11->01->00.
  - Phase wraps freely. Exactly one output bit toggles per step.
- steer_a/steer_b are the registered phase bits: a step decided on cycle N is visible after edge N (1-cycle latency).
- First step after onset lands clkdiv+2 cycles after the input edge: 1 cycle to register dir, then clkdiv+1 cycles of count.
- clkdiv=0: thr=0, so one step every cycle while held.
- Channels are fully independent. clkdiv is shared.
- Inputs are assumed synchronous to CLK. Synchronisers are upstream.

Optional Feature:
- Macro: QUAD_ACCEL_EN.
- Defined: thr depends on the channel's hold count.
  - hold < ACCEL_STEPS: thr = clkdiv.
  - ACCEL_STEPS <= hold < 2*ACCEL_STEPS: thr = clkdiv>>1.
  - hold >= 2*ACCEL_STEPS: thr = clkdiv>>2.
  - Idle or reversal clears hold, returning to base rate.
- Not defined: thr = clkdiv always. The hold counter is not synthesised.

Test Plan:
- Reset: Reset_n=0 mid-step with right[0]=1 -> steer_a=steer_b=moving=0 immediately (async). After release, first step lands clkdiv+2 cycles later.
- Right hold, clkdiv=3, channel 0, 40 cycles -> phase 00,01,11,10,00… with one toggle every 4 cycles. Channel 1 stays 00.
- Reversal: right held 2 steps (phase 11), then left -> no step on reversal cycle. Next step after 4 counted cycles goes 11->01.
- Both left and right high on channel 1 for 20 cycles, clkdiv=3 -> no phase change, moving[1]=0.
- clkdiv=0 with left held -> phase changes every cycle: 00,10,11,01,00.
- QUAD_ACCEL_EN, ACCEL_STEPS=8, clkdiv=15, right held -> steps 1-8 at 16-cycle spacing, 9-16 at 8, thereafter 4. Release for one cycle, re-press -> back to 16. Without the macro -> constant 16.
